// File: rtl/conv_pkg.sv
// Shared definitions for the conv/pool/flatten sequencer and its datapath.
// Holds flag bit positions, the sequencer state encoding and phase lengths.
package conv_pkg;

    localparam int FLAG_W = 12;

    localparam int F_GEN_IN_ADDR    = 0;
    localparam int F_READ_IN_ENB    = 1;
    localparam int F_CONV_RELU_ENB  = 2;
    localparam int F_WRITE_CONV_ENB = 3;
    localparam int F_GEN_CONV_ADDR  = 4;
    localparam int F_READ_CONV_ENB  = 5;
    localparam int F_WRITE_POOL_ENB = 6;
    localparam int F_WRITE_FLAT_ENB = 7;

    // Address generation leads the read enables by this many cycles
    localparam int RD_SKEW = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        WCONV,
        RDL0,
        POOL,
        FLAT
    } state_t;

    function automatic int load_len(input int in_buf);
        return 3 * in_buf + RD_SKEW;
    endfunction

    function automatic int conv_len(input int out_buf);
        return out_buf + 1;
    endfunction

    function automatic int wconv_len(input int out_buf);
        return 2 * out_buf;
    endfunction

    function automatic int rdl0_len(input int l0);
        return 2 * l0 + RD_SKEW;
    endfunction

    function automatic int pool_len(input int pool);
        return 2 * pool;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_phase_counter.sv
// phase_counter: step counter that clears itself on terminal count.
// Ports: en (count while high, else held at 0), len (phase length),
// cnt (registered count), cnt_next (value after this edge), tc (last step).
module phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] len,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_next,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        tc    = en && (cnt_q == len - 1'b1);
        cnt_d = (en && !tc) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: walks the datapath through load/conv/write per row, then
// layer-0 readback, pool and flatten. Ports: ready (start, IDLE only),
// busy, flags (phase enables), local_idx (step in phase), row_idx.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int LOCAL_IDX_WIDTH = 16,
    parameter int IN_BUFFER_SIZE  = 16,
    parameter int OUT_BUFFER_SIZE = 3,
    parameter int ROWS            = 64,
    parameter int L0_SIZE         = 4096,
    parameter int POOL_SIZE       = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready,
    output logic                       busy,
    output logic [FLAG_W-1:0]          flags,
    output logic [LOCAL_IDX_WIDTH-1:0] local_idx,
    output logic [7:0]                 row_idx
);

    localparam int W = LOCAL_IDX_WIDTH;

    localparam logic [W-1:0] LOAD_LEN  = W'(load_len(IN_BUFFER_SIZE));
    localparam logic [W-1:0] CONV_LEN  = W'(conv_len(OUT_BUFFER_SIZE));
    localparam logic [W-1:0] WCONV_LEN = W'(wconv_len(OUT_BUFFER_SIZE));
    localparam logic [W-1:0] RDL0_LEN  = W'(rdl0_len(L0_SIZE));
    localparam logic [W-1:0] POOL_LEN  = W'(pool_len(POOL_SIZE));
    localparam logic [W-1:0] IN_GEN_END  = W'(3 * IN_BUFFER_SIZE);
    localparam logic [W-1:0] L0_GEN_END  = W'(2 * L0_SIZE);
    localparam logic [W-1:0] SKEW        = W'(RD_SKEW);
    localparam logic [7:0]   ROW_LAST    = 8'(ROWS - 1);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [7:0]        row_q, row_d;
    logic [W-1:0]      len;
    logic [W-1:0]      idx_q;
    logic [W-1:0]      idx_next;
    logic              tc;

    // Flags are derived from the post-edge state/index so that the
    // registered flags always line up with the registered local_idx.
    function automatic logic [FLAG_W-1:0] phase_flags(
        input state_t       s,
        input logic [W-1:0] i
    );
        logic [FLAG_W-1:0] f;
        f = '0;
        unique case (s)
            LOAD: begin
                f[F_GEN_IN_ADDR] = (i < IN_GEN_END);
                f[F_READ_IN_ENB] = (i >= SKEW);
            end
            CONV:  f[F_CONV_RELU_ENB]  = 1'b1;
            WCONV: f[F_WRITE_CONV_ENB] = 1'b1;
            RDL0: begin
                f[F_GEN_CONV_ADDR] = (i < L0_GEN_END);
                f[F_READ_CONV_ENB] = (i >= SKEW);
            end
            POOL:  f[F_WRITE_POOL_ENB] = 1'b1;
            FLAT:  f[F_WRITE_FLAT_ENB] = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    always_comb begin
        len = W'(1);
        unique case (state_q)
            LOAD:    len = LOAD_LEN;
            CONV:    len = CONV_LEN;
            WCONV:   len = WCONV_LEN;
            RDL0:    len = RDL0_LEN;
            POOL:    len = POOL_LEN;
            FLAT:    len = POOL_LEN;
            default: len = W'(1);
        endcase
    end

    phase_counter #(
        .WIDTH (W)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q != IDLE),
        .len      (len),
        .cnt      (idx_q),
        .cnt_next (idx_next),
        .tc       (tc)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d = LOAD;
                    row_d   = '0;
                end
            end
            LOAD:  if (tc) state_d = CONV;
            CONV:  if (tc) state_d = WCONV;
            WCONV: begin
                if (tc) begin
                    if (row_q < ROW_LAST) begin
                        row_d   = row_q + 8'd1;
                        state_d = LOAD;
                    end else begin
                        state_d = RDL0;
                    end
                end
            end
            RDL0:    if (tc) state_d = POOL;
            POOL:    if (tc) state_d = FLAT;
            FLAT:    if (tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        flags_d = phase_flags(state_d, idx_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            flags_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            flags_q <= flags_d;
            row_q   <= row_d;
        end
    end

    assign busy      = busy_q;
    assign flags     = flags_q;
    assign local_idx = idx_q;
    assign row_idx   = row_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: cycle model feeds a scoreboard queue,
// plus fixed-offset checks along the sequence.
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    localparam int ROWS = 12;
    localparam int IBS  = 16;
    localparam int OBS  = 3;
    localparam int L0   = 4096;
    localparam int PS   = 1024;
    localparam int RUN_LEN = ROWS * ((3 * IBS + 2) + (OBS + 1) + 2 * OBS)
                           + (2 * L0 + 2) + 4 * PS;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [11:0] flags;
    logic [15:0] local_idx;
    logic [7:0]  row_idx;

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .LOCAL_IDX_WIDTH (16),
        .IN_BUFFER_SIZE  (IBS),
        .OUT_BUFFER_SIZE (OBS),
        .ROWS            (ROWS),
        .L0_SIZE         (L0),
        .POOL_SIZE       (PS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .busy      (busy),
        .flags     (flags),
        .local_idx (local_idx),
        .row_idx   (row_idx)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    state_t m_st  = IDLE;
    int     m_idx = 0;
    int     m_row = 0;
    int     bt    = 0;
    int     run_no = 0;
    logic [36:0] sbq[$];

    function automatic int m_len(input state_t s);
        case (s)
            LOAD:       return 3 * IBS + 2;
            CONV:       return OBS + 1;
            WCONV:      return 2 * OBS;
            RDL0:       return 2 * L0 + 2;
            POOL, FLAT: return 2 * PS;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [11:0] m_flags(input state_t s, input int i);
        logic [11:0] f;
        f = 12'h000;
        case (s)
            LOAD: begin
                f[0] = (i < 3 * IBS);
                f[1] = (i >= 2);
            end
            CONV:  f[2] = 1'b1;
            WCONV: f[3] = 1'b1;
            RDL0: begin
                f[4] = (i < 2 * L0);
                f[5] = (i >= 2);
            end
            POOL:  f[6] = 1'b1;
            FLAT:  f[7] = 1'b1;
            default: f = 12'h000;
        endcase
        return f;
    endfunction

    task automatic model_advance();
        if (reset) begin
            m_st = IDLE; m_idx = 0; m_row = 0;
        end else if (m_st == IDLE) begin
            if (ready) begin
                m_st = LOAD; m_idx = 0; m_row = 0;
            end
        end else if (m_idx < m_len(m_st) - 1) begin
            m_idx++;
        end else begin
            m_idx = 0;
            case (m_st)
                LOAD:  m_st = CONV;
                CONV:  m_st = WCONV;
                WCONV: begin
                    if (m_row < ROWS - 1) begin
                        m_row++;
                        m_st = LOAD;
                    end else begin
                        m_st = RDL0;
                    end
                end
                RDL0:    m_st = POOL;
                POOL:    m_st = FLAT;
                default: m_st = IDLE;
            endcase
        end
    endtask

    task automatic spot();
        logic [35:0] a;
        a = {flags, local_idx, row_idx};
        if (run_no == 1) begin
            case (bt)
                0, 1:  chk("load_gen", 64'(a), 64'({12'h001, 16'(bt), 8'd0}));
                2, 47: chk("load_both", 64'(a), 64'({12'h003, 16'(bt), 8'd0}));
                48, 49: chk("load_rd", 64'(a), 64'({12'h002, 16'(bt), 8'd0}));
                50:    chk("conv0", 64'(a), 64'({12'h004, 16'd0, 8'd0}));
                54:    chk("wconv0", 64'(a), 64'({12'h008, 16'd0, 8'd0}));
                60:    chk("row1", 64'(a), 64'({12'h001, 16'd0, 8'd1}));
                720:   chk("rdl0_0", 64'(a), 64'({12'h010, 16'd0, 8'(ROWS - 1)}));
                8913:  chk("rdl0_end", 64'(a), 64'({12'h020, 16'd8193, 8'(ROWS - 1)}));
                8914:  chk("pool0", 64'(a), 64'({12'h040, 16'd0, 8'(ROWS - 1)}));
                10961: chk("pool_end", 64'(a), 64'({12'h040, 16'd2047, 8'(ROWS - 1)}));
                10962: chk("flat0", 64'(a), 64'({12'h080, 16'd0, 8'(ROWS - 1)}));
                13009: chk("flat_end", 64'(a), 64'({12'h080, 16'd2047, 8'(ROWS - 1)}));
                default: ;
            endcase
        end
    endtask

    task automatic step();
        logic [36:0] e;
        logic [36:0] a;
        model_advance();
        sbq.push_back({m_st != IDLE, m_flags(m_st, m_idx),
                       16'(m_idx), 8'(m_row)});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        a = {busy, flags, local_idx, row_idx};
        chk("sb", 64'(a), 64'(e));
        chk("onehot", 64'($countones(flags[7:0] & 8'hCC) <= 1), 64'(1));
        chk("hi_zero", 64'(flags[11:8]), 64'(0));
        chk("idx_rng", 64'(int'(local_idx) < m_len(m_st)), 64'(1));
        if (e[36]) begin
            spot();
            bt++;
        end else begin
            bt = 0;
        end
        if (errors > 200) begin
            $display("Simulation finished: %0d checks, %0d errors",
                     checks, errors);
            $finish;
        end
    endtask

    int   busy_cnt;
    int   rises;
    int   gap;
    logic prev_busy;
    logic found;

    initial begin
        reset  = 1'b1;
        ready  = 1'b0;
        run_no = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) reset = 1'b0;
            step();
            if (i == 0) begin
                chk("reset_state", 64'({busy, flags, local_idx, row_idx}),
                    64'(0));
            end
        end

        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_row", 64'(row_idx), 64'(0));
        busy_cnt = 1;
        for (int i = 0; i < RUN_LEN + 5; i++) begin
            ready = (i == 100 || i == 9000);
            step();
            if (busy) busy_cnt++;
        end
        ready = 1'b0;
        chk("busy_len", 64'(busy_cnt), 64'(RUN_LEN));
        chk("idle_after", 64'({busy, flags}), 64'(0));

        run_no    = 2;
        ready     = 1'b1;
        rises     = 0;
        gap       = 0;
        prev_busy = busy;
        found     = 1'b0;
        for (int i = 0; i < 2 * RUN_LEN + 10; i++) begin
            step();
            if (busy && !prev_busy) rises++;
            if (!busy && rises == 1) begin
                gap++;
                chk("gap_flags", 64'(flags), 64'(0));
            end
            prev_busy = busy;
            if (rises == 2 && m_st == CONV && m_row == 10 && m_idx == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_row10", 64'(found), 64'(1));
        chk("idle_gap", 64'(gap), 64'(1));
        chk("pre_rst", 64'({flags, local_idx, row_idx}),
            64'({12'h004, 16'd2, 8'd10}));

        reset = 1'b1;
        ready = 1'b0;
        step();
        chk("mid_reset", 64'({busy, flags, local_idx, row_idx}), 64'(0));
        reset = 1'b0;
        step();
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("restart", 64'({busy, flags, local_idx, row_idx}),
            64'({1'b1, 12'h001, 16'd0, 8'd0}));
        for (int i = 0; i < 60; i++) step();
        chk("restart_row1", 64'({flags, local_idx, row_idx}),
            64'({12'h001, 16'd0, 8'd1}));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
